// File: rtl/output_port_arbiter_if.sv
// Handshake bundle between the input FIFOs, sibling arbiters and one
// output-port arbiter of the 3-input switch.
interface output_port_arbiter_if;
   logic [7:0] data1;
   logic [7:0] data2;
   logic [7:0] data3;
   logic       empty1;
   logic       empty2;
   logic       empty3;
   logic [2:0] busy_in;
   logic       out_full;
   logic       rdreq1;
   logic       rdreq2;
   logic       rdreq3;
   logic [2:0] busy_out;
   logic [1:0] sel;
   logic [7:0] out_data;
   logic       out_valid;
   logic       err;

   modport master (
      output data1, data2, data3,
      output empty1, empty2, empty3,
      output busy_in, out_full,
      input  rdreq1, rdreq2, rdreq3,
      input  busy_out, sel, out_data, out_valid, err
   );

   modport slave (
      input  data1, data2, data3,
      input  empty1, empty2, empty3,
      input  busy_in, out_full,
      output rdreq1, rdreq2, rdreq3,
      output busy_out, sel, out_data, out_valid, err
   );
endinterface

// File: rtl/output_port_arbiter.sv
// Round-robin packet-locking arbiter for one switch output port.
// Define ARB_WATCHDOG_EN to abort packets stalled for TIMEOUT cycles.
module output_port_arbiter #(
   parameter logic [1:0]  PORT_ID = 2'b01,
   parameter int unsigned TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  rst_n,
   output_port_arbiter_if.slave port
);
   typedef enum logic {IDLE, XFER} state_t;

   if (PORT_ID == 2'b00) begin : g_bad_port
      $error("PORT_ID must be 2'b01..2'b11");
   end
   if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
      $error("TIMEOUT must fit the 4-bit stall counter");
   end

   state_t     state, state_n;
   logic [1:0] ptr, ptr_n;
   logic [3:0] cnt, cnt_n;
   logic [1:0] sel_q, sel_n;
   logic [2:0] busy_q, busy_n;
   logic [7:0] odata_q, odata_n;
   logic       ovalid_q, ovalid_n;
   logic [7:0] data [3];
   logic [2:0] empty, req, rdreq;
   logic [1:0] g, pick;
   logic       found, pop, done, abort;
   logic       unused;

   assign data[0] = port.data1;
   assign data[1] = port.data2;
   assign data[2] = port.data3;
   assign empty   = {port.empty3, port.empty2, port.empty1};
   assign unused  = ^{data[0][7:5], data[1][7:5], data[2][7:5]};

   assign port.rdreq1    = rdreq[0];
   assign port.rdreq2    = rdreq[1];
   assign port.rdreq3    = rdreq[2];
   assign port.busy_out  = busy_q;
   assign port.sel       = sel_q;
   assign port.out_data  = odata_q;
   assign port.out_valid = ovalid_q;
   assign g              = sel_q - 2'd1;

`ifdef ARB_WATCHDOG_EN
   logic [3:0] stall, stall_n;
   logic       err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall <= '0;
         err_q <= 1'b0;
      end else begin
         stall <= stall_n;
         err_q <= abort;
      end
   end

   assign port.err = err_q;
`else
   assign port.err = 1'b0;
`endif

   always_comb begin
      for (int k = 0; k < 3; k++) begin
         req[k] = !empty[k] && (data[k][1:0] == PORT_ID)
                  && !port.busy_in[k] && !busy_q[k];
      end
   end

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      cnt_n    = cnt;
      sel_n    = sel_q;
      busy_n   = busy_q;
      odata_n  = odata_q;
      ovalid_n = 1'b0;
      rdreq    = '0;
      found    = 1'b0;
      pick     = '0;
      pop      = 1'b0;
      done     = 1'b0;
      abort    = 1'b0;
`ifdef ARB_WATCHDOG_EN
      stall_n  = '0;
`endif
      unique case (state)
         IDLE: begin
            // first requester at or after ptr, wrapping 3 -> 1
            for (int k = 0; k < 3; k++) begin
               if (!found && req[(int'(ptr) + k) % 3]) begin
                  found = 1'b1;
                  pick  = 2'((int'(ptr) + k) % 3);
               end
            end
            if (found) begin
               state_n = XFER;
               sel_n   = pick + 2'd1;
               busy_n  = 3'b001 << pick;
               cnt_n   = {1'b0, data[pick][4:2]} + 4'd1;
            end
         end
         XFER: begin
            pop      = !empty[g] && !port.out_full;
            rdreq[g] = pop;
            if (pop) begin
               odata_n  = data[g];
               ovalid_n = 1'b1;
               cnt_n    = cnt - 4'd1;
               done     = (cnt == 4'd1);
            end
`ifdef ARB_WATCHDOG_EN
            stall_n = pop ? 4'd0 : stall + 4'd1;
            abort   = !pop && (stall == 4'(TIMEOUT - 1));
`endif
            if (done || abort) begin
               state_n = IDLE;
               sel_n   = '0;
               busy_n  = '0;
               ptr_n   = (g == 2'd2) ? 2'd0 : g + 2'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         sel_q    <= '0;
         busy_q   <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         cnt      <= cnt_n;
         sel_q    <= sel_n;
         busy_q   <= busy_n;
         odata_q  <= odata_n;
         ovalid_q <= ovalid_n;
      end
   end
endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter (PORT_ID = 2'b10).
// FIFO models feed the DUT; a scoreboard checks every forwarded flit.
module tb_output_port_arbiter;
   typedef struct {
      int         src;
      logic [7:0] hdr;
      logic [2:0] busy;
      logic [1:0] exp_sel;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   nvalid   = 0;
   int   nrd      = 0;
   logic [2:0] cap = '0;
   logic [7:0] fq1[$], fq2[$], fq3[$], sbq[$];
   logic [1:0] rr_exp [6] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0};
   vec_t vecs [6];

   output_port_arbiter_if bus();

   output_port_arbiter #(.PORT_ID(2'b10), .TIMEOUT(15)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .port (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      bus.data1  = (fq1.size() != 0) ? fq1[0] : 8'h00;
      bus.data2  = (fq2.size() != 0) ? fq2[0] : 8'h00;
      bus.data3  = (fq3.size() != 0) ? fq3[0] : 8'h00;
      bus.empty1 = (fq1.size() == 0);
      bus.empty2 = (fq2.size() == 0);
      bus.empty3 = (fq3.size() == 0);
   endtask

   task automatic push(input int src, input logic [7:0] v, input bit exp);
      case (src)
         1: fq1.push_back(v);
         2: fq2.push_back(v);
         default: fq3.push_back(v);
      endcase
      if (exp) sbq.push_back(v);
      refresh();
   endtask

   task automatic push_pkt(input int src, input logic [7:0] hdr, input bit exp);
      int len;
      len = int'(hdr[4:2]);
      push(src, hdr, exp);
      for (int p = 1; p <= len; p++) push(src, 8'((src << 4) | p), exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      fq1.delete();
      fq2.delete();
      fq3.delete();
      sbq.delete();
      bus.busy_in  = '0;
      bus.out_full = 1'b0;
      refresh();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // rdreq is sampled just before the edge the DUT pops on
   always @(negedge clk) begin
      #4;
      cap = {bus.rdreq3, bus.rdreq2, bus.rdreq1};
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (cap[0] && fq1.size() != 0) void'(fq1.pop_front());
         if (cap[1] && fq2.size() != 0) void'(fq2.pop_front());
         if (cap[2] && fq3.size() != 0) void'(fq3.pop_front());
         if (cap != 3'b000) nrd++;
      end
      refresh();
   end

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         nvalid++;
         if (sbq.size() == 0) check("sb_extra", bus.out_data, 32'hFFFF_FFFF);
         else check("sb_flit", bus.out_data, sbq.pop_front());
      end
   end

   initial begin
      int base_v, base_r, len, wd_n;
      vecs[0] = '{2, 8'h0A, 3'b000, 2'd2};
      vecs[1] = '{1, 8'hE6, 3'b000, 2'd1};
      vecs[2] = '{3, 8'h1E, 3'b000, 2'd3};
      vecs[3] = '{1, 8'h01, 3'b000, 2'd0};
      vecs[4] = '{3, 8'h02, 3'b100, 2'd0};
      vecs[5] = '{2, 8'h02, 3'b001, 2'd2};
      rst_n = 1'b0;
      bus.busy_in  = '0;
      bus.out_full = 1'b0;
      refresh();

      do_reset();
      check("rst_sel", bus.sel, 0);
      check("rst_busy", bus.busy_out, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_err", bus.err, 0);
      check("rst_rdreq", {bus.rdreq3, bus.rdreq2, bus.rdreq1}, 0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         len = int'(vecs[i].hdr[4:2]);
         bus.busy_in = vecs[i].busy;
         base_v = nvalid;
         base_r = nrd;
         push_pkt(vecs[i].src, vecs[i].hdr, vecs[i].exp_sel != 0);
         @(negedge clk);
         check("vec_sel", bus.sel, vecs[i].exp_sel);
         check("vec_busy", bus.busy_out,
               (vecs[i].exp_sel != 0) ? (3'b001 << (vecs[i].exp_sel - 1)) : 3'b000);
         repeat (12) @(negedge clk);
         check("vec_len", nvalid - base_v, (vecs[i].exp_sel != 0) ? len + 1 : 0);
         check("vec_rd", nrd - base_r, (vecs[i].exp_sel != 0) ? len + 1 : 0);
         check("vec_end_sel", bus.sel, 0);
         check("vec_end_busy", bus.busy_out, 0);
         check("vec_sb_empty", sbq.size(), 0);
      end

      // asynchronous reset in the middle of a packet
      do_reset();
      push_pkt(2, 8'h1E, 1'b1);
      repeat (3) @(negedge clk);
      check("mid_valid_pre", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_sel", bus.sel, 0);
      check("mid_busy", bus.busy_out, 0);
      check("mid_rdreq", bus.rdreq2, 0);
      check("mid_valid", bus.out_valid, 0);
      check("mid_data", bus.out_data, 0);
      do_reset();
      @(negedge clk);
      check("mid_idle_sel", bus.sel, 0);

      // round robin across simultaneous L=0 headers, then wrap 3 -> 1
      do_reset();
      push(1, 8'hE2, 1'b1);
      push(2, 8'h22, 1'b1);
      push(3, 8'h42, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_sel", bus.sel, rr_exp[k]);
      end
      push(1, 8'h62, 1'b1);
      push(3, 8'hA2, 1'b1);
      @(negedge clk);
      check("rr_wrap", bus.sel, 1);
      repeat (4) @(negedge clk);
      check("rr_sb_empty", sbq.size(), 0);

      // backpressure for 4 cycles mid-packet
      do_reset();
      base_v = nvalid;
      push_pkt(1, 8'h16, 1'b1);
      repeat (2) @(negedge clk);
      bus.out_full = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 check("bp_rdreq", bus.rdreq1, 0);
         @(negedge clk);
         check("bp_valid", bus.out_valid, 0);
         check("bp_busy", bus.busy_out, 3'b001);
      end
      bus.out_full = 1'b0;
      repeat (10) @(negedge clk);
      check("bp_len", nvalid - base_v, 6);
      check("bp_sb_empty", sbq.size(), 0);

      // sibling holds input 1
      do_reset();
      bus.busy_in = 3'b001;
      push(1, 8'h02, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bx_sel", bus.sel, 0);
         check("bx_rdreq", bus.rdreq1, 0);
      end
      bus.busy_in = 3'b000;
      @(negedge clk);
      check("bx_grant", bus.sel, 1);
      repeat (3) @(negedge clk);
      check("bx_sb_empty", sbq.size(), 0);

      // granted FIFO runs dry after the header
      do_reset();
      push(3, 8'h06, 1'b1);
      @(negedge clk);
      check("wd_grant", bus.sel, 3);
`ifdef ARB_WATCHDOG_EN
      wd_n = 0;
      for (int n = 1; n <= 30 && wd_n == 0; n++) begin
         @(negedge clk);
         if (bus.err) wd_n = n;
      end
      check("wd_cycle", wd_n, 16);
      check("wd_sel", bus.sel, 0);
      check("wd_busy", bus.busy_out, 0);
      @(negedge clk);
      check("wd_pulse", bus.err, 0);
`else
      wd_n = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (bus.err) wd_n++;
      end
      check("nowd_err", wd_n, 0);
      check("nowd_sel", bus.sel, 3);
      check("nowd_busy", bus.busy_out, 3'b100);
`endif
      check("wd_sb_empty", sbq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
